// File: rtl/pe_array_ctrl_pkg.sv
// Shared types and sizing for the PE array sequencer and the tile scheduler.
// Row counts use 6 bits so the full 0..32 range is representable.
package pe_array_pkg;

    localparam int ROW_NUM     = 32;
    localparam int COL_NUM     = 32;
    localparam int PROD_CYCLES = 4;
    localparam int CNT_W       = 16;
    localparam int ROW_W       = 6;
    localparam int PASS_W      = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        WEN     = 3'd2,
        FEED    = 3'd3,
        FILL    = 3'd4,
        COMPUTE = 3'd5,
        OUT     = 3'd6,
        DONE    = 3'd7
    } ctrl_state_e;

    typedef struct packed {
        logic [ROW_W-1:0]  rows;
        logic [PASS_W-1:0] pass_if;
        logic [CNT_W-1:0]  num_ifmap;
    } pe_tile_cmd_t;

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Command, buffer and PE-array handshake bundle around the array sequencer.
// master = the sequencer, slave = scheduler/buffers/array/reducer side.
interface pe_array_ctrl_if
    import pe_array_pkg::*;
#(
    parameter int CNT_W = pe_array_pkg::CNT_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ROW_W-1:0]  cmd_rows;
    logic [PASS_W-1:0] cmd_pass_if;
    logic [CNT_W-1:0]  cmd_num_ifmap;
    logic              w_req;
    logic              w_valid;
    logic              if_req;
    logic              if_valid;
    logic [ROW_W-1:0]  array_weight_en;
    logic [PASS_W-1:0] pe_pass_if;
    logic              prod_out_en;
    logic              opsum_valid;
    logic              opsum_ready;
    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_rows, cmd_pass_if, cmd_num_ifmap,
        input  w_valid, if_valid, opsum_ready,
        output cmd_ready, w_req, if_req, array_weight_en, pe_pass_if,
        output prod_out_en, opsum_valid, busy, done
    );

    modport slave (
        output cmd_valid, cmd_rows, cmd_pass_if, cmd_num_ifmap,
        output w_valid, if_valid, opsum_ready,
        input  cmd_ready, w_req, if_req, array_weight_en, pe_pass_if,
        input  prod_out_en, opsum_valid, busy, done
    );

endinterface

// File: rtl/pe_array_ctrl.sv
// Tile sequencer for the PE array: weight load, per-vector feed/fill/compute, row-sum handoff.
// Latency: first row-sum valid rows+7 cycles after command accept, then rows+5 cycles per vector.
// Backpressure: opsum_ready low freezes the FSM in OUT; no ifmap request, prod_out_en held low.
module pe_array_ctrl
    import pe_array_pkg::*;
#(
    parameter int ROW_NUM     = pe_array_pkg::ROW_NUM,
    parameter int PROD_CYCLES = pe_array_pkg::PROD_CYCLES,
    parameter int CNT_W       = pe_array_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    pe_array_ctrl_if.master ctrl
);

    localparam logic [ROW_W-1:0] ROWS_MAX = ROW_W'(ROW_NUM);
    localparam logic [ROW_W-1:0] PROD_LD  = ROW_W'(PROD_CYCLES);

    ctrl_state_e       state_q;
    ctrl_state_e       state_d;
    logic              armed_q;
    logic [ROW_W-1:0]  rows_q;
    logic [PASS_W-1:0] pass_q;
    logic [ROW_W-1:0]  cyc_q;
    logic [CNT_W-1:0]  rem_q;
    logic [ROW_W-1:0]  rows_sat;
    logic              cmd_fire;
    logic              if_fire;
    logic              out_fire;

    assign rows_sat = (ctrl.cmd_rows > ROWS_MAX) ? ROWS_MAX : ctrl.cmd_rows;
    assign cmd_fire = (state_q == IDLE) && armed_q && ctrl.cmd_valid;
    assign if_fire  = (state_q == FEED) && ctrl.if_valid;
    assign out_fire = (state_q == OUT) && ctrl.opsum_ready;

    // armed_q keeps cmd_ready low while reset is held and for the release cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (rows_sat == '0 || ctrl.cmd_num_ifmap == '0) state_d = DONE;
                    else                                            state_d = LOAD_W;
                end
            end
            LOAD_W:  if (ctrl.w_valid) state_d = WEN;
            WEN:     state_d = FEED;
            FEED:    if (if_fire) state_d = (rows_q > ROW_W'(1)) ? FILL : COMPUTE;
            FILL:    if (cyc_q <= ROW_W'(1)) state_d = COMPUTE;
            COMPUTE: if (cyc_q <= ROW_W'(1)) state_d = OUT;
            OUT:     if (out_fire) state_d = (rem_q <= CNT_W'(1)) ? DONE : FEED;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cyc_q counts the ripple fill, then is reloaded for the compute window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_q <= '0;
            pass_q <= '0;
            cyc_q  <= '0;
            rem_q  <= '0;
        end else begin
            if (cmd_fire) begin
                rows_q <= rows_sat;
                pass_q <= ctrl.cmd_pass_if;
                rem_q  <= ctrl.cmd_num_ifmap;
            end
            if (if_fire) begin
                cyc_q <= (rows_q > ROW_W'(1)) ? rows_q - ROW_W'(1) : PROD_LD;
            end else if (state_q == FILL) begin
                cyc_q <= (cyc_q <= ROW_W'(1)) ? PROD_LD : cyc_q - ROW_W'(1);
            end else if (state_q == COMPUTE && cyc_q != '0) begin
                cyc_q <= cyc_q - ROW_W'(1);
            end
            if (out_fire && rem_q != '0) begin
                rem_q <= rem_q - CNT_W'(1);
            end
        end
    end

    assign ctrl.cmd_ready       = (state_q == IDLE) && armed_q;
    assign ctrl.w_req           = (state_q == LOAD_W) || (state_q == WEN);
    assign ctrl.array_weight_en = (state_q == WEN) ? rows_q : '0;
    assign ctrl.if_req          = (state_q == FEED);
    assign ctrl.prod_out_en     = (state_q == COMPUTE);
    assign ctrl.opsum_valid     = (state_q == OUT);
    assign ctrl.pe_pass_if      = (state_q == IDLE) ? '0 : pass_q;
    assign ctrl.busy            = (state_q != IDLE);
    assign ctrl.done            = (state_q == DONE);

endmodule
